// File: rtl/pong_state_reader.sv
// -----------------------------------------------------------------------------
// pong_state_reader
//
// Host-side reader for the pong core's multiplexed 8-bit state output. Steps the
// core's output select through ball x, ball y, left paddle and right paddle,
// lets the core's registered output settle after each select change, captures
// each field into a shadow snapshot, then re-reads ball x to detect a snapshot
// torn by a core update. A coherent (or, after retries run out, torn) snapshot
// is published on a valid/ready handshake. Per-side score counters are derived
// from the published ball x reaching a screen edge.
//
// Ports:
//   clk          single clock
//   rst          asynchronous active-high reset
//   sel_out      core output select (0=ball x, 1=ball y, 2=left pad, 3=right pad)
//   data_in      core's registered state output
//   snap_ball_x  published ball x
//   snap_ball_y  published ball y
//   snap_lpad    published left paddle y
//   snap_rpad    published right paddle y
//   snap_torn    snapshot never verified within MAX_RETRY retries
//   snap_valid   snapshot available
//   snap_ready   consumer accepts the snapshot
//   score_left   points for the left player (ball reached the right edge)
//   score_right  points for the right player (ball reached the left edge)
//   score_clr    synchronous clear of both scores
// -----------------------------------------------------------------------------
module pong_state_reader #(
   parameter int SETTLE        = 2,
   parameter int POLL_INTERVAL = 64,
   parameter int MAX_RETRY     = 3,
   parameter int SCREEN_WIDTH  = 160
) (
   input  logic       clk,
   input  logic       rst,
   output logic [1:0] sel_out,
   input  logic [7:0] data_in,
   output logic [7:0] snap_ball_x,
   output logic [7:0] snap_ball_y,
   output logic [7:0] snap_lpad,
   output logic [7:0] snap_rpad,
   output logic       snap_torn,
   output logic       snap_valid,
   input  logic       snap_ready,
   output logic [7:0] score_left,
   output logic [7:0] score_right,
   input  logic       score_clr
);

   localparam int               CNT_W      = 16;
   localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE);
   localparam logic [CNT_W-1:0] POLL_LD    = CNT_W'(POLL_INTERVAL);
   localparam logic [7:0]       RETRY_MAX  = 8'(MAX_RETRY);
   localparam logic [7:0]       RIGHT_EDGE = 8'(SCREEN_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_SELECT,
      ST_SETTLE,
      ST_VERIFY_SEL,
      ST_VERIFY,
      ST_PUBLISH
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       idx_q, idx_d;
   // One down-counter serves both the poll interval (WAIT) and the settle
   // windows (SETTLE/VERIFY); the two never overlap.
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [7:0]       retry_q, retry_d;
   logic             torn_q, torn_d;
   logic [7:0]       shadow_q [0:3];
   logic [7:0]       shadow_d [0:3];
   logic [1:0]       sel_q, sel_d;
   logic [7:0]       snap_x_q, snap_x_d;
   logic [7:0]       snap_y_q, snap_y_d;
   logic [7:0]       snap_l_q, snap_l_d;
   logic [7:0]       snap_r_q, snap_r_d;
   logic             snap_torn_q, snap_torn_d;
   logic             snap_valid_q, snap_valid_d;
   logic [7:0]       score_l_q, score_l_d;
   logic [7:0]       score_r_q, score_r_d;
   logic [7:0]       prev_x_q, prev_x_d;
   logic             inc_left, inc_right;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      timer_d      = timer_q;
      retry_d      = retry_q;
      torn_d       = torn_q;
      shadow_d     = shadow_q;
      sel_d        = sel_q;
      snap_x_d     = snap_x_q;
      snap_y_d     = snap_y_q;
      snap_l_d     = snap_l_q;
      snap_r_d     = snap_r_q;
      snap_torn_d  = snap_torn_q;
      snap_valid_d = snap_valid_q;
      prev_x_d     = prev_x_q;
      inc_left     = 1'b0;
      inc_right    = 1'b0;

      case (state_q)
         ST_WAIT: begin
            if (timer_q <= CNT_W'(1)) begin
               state_d = ST_SELECT;
               idx_d   = 2'd0;
               sel_d   = 2'd0;
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end

         ST_SELECT: begin
            timer_d = SETTLE_LD;
            state_d = ST_SETTLE;
         end

         ST_SETTLE: begin
            if (timer_q <= CNT_W'(1)) begin
               shadow_d[idx_q] = data_in;
               if (idx_q != 2'd3) begin
                  // sel_out moves together with the SELECT entry so it is
                  // already stable for the whole next settle window.
                  idx_d   = idx_q + 2'd1;
                  sel_d   = idx_q + 2'd1;
                  state_d = ST_SELECT;
               end else begin
                  sel_d   = 2'd0;
                  state_d = ST_VERIFY_SEL;
               end
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end

         ST_VERIFY_SEL: begin
            timer_d = SETTLE_LD;
            state_d = ST_VERIFY;
         end

         ST_VERIFY: begin
            if (timer_q <= CNT_W'(1)) begin
               // A core update between the ball x capture and now shows up
               // as a changed ball x; rescan rather than publish a mix.
               if (data_in == shadow_q[0]) begin
                  torn_d  = 1'b0;
                  state_d = ST_PUBLISH;
               end else if (retry_q < RETRY_MAX) begin
                  retry_d = retry_q + 8'd1;
                  idx_d   = 2'd0;
                  sel_d   = 2'd0;
                  state_d = ST_SELECT;
               end else begin
                  torn_d  = 1'b1;
                  state_d = ST_PUBLISH;
               end
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end

         ST_PUBLISH: begin
            // snap_valid is always low on entry, so it marks the entry cycle.
            if (!snap_valid_q) begin
               snap_x_d     = shadow_q[0];
               snap_y_d     = shadow_q[1];
               snap_l_d     = shadow_q[2];
               snap_r_d     = shadow_q[3];
               snap_torn_d  = torn_q;
               snap_valid_d = 1'b1;
               // Torn snapshots neither score nor become the edge reference.
               if (!torn_q) begin
                  inc_right = (shadow_q[0] == 8'd0) && (prev_x_q != 8'd0);
                  inc_left  = (shadow_q[0] == RIGHT_EDGE) && (prev_x_q != RIGHT_EDGE);
                  prev_x_d  = shadow_q[0];
               end
            end else if (snap_ready) begin
               snap_valid_d = 1'b0;
               retry_d      = 8'd0;
               timer_d      = POLL_LD;
               state_d      = ST_WAIT;
            end
         end

         default: begin
            state_d = ST_WAIT;
            timer_d = CNT_W'(1);
         end
      endcase

      score_l_d = score_l_q;
      score_r_d = score_r_q;
      if (score_clr) begin
         score_l_d = 8'd0;
         score_r_d = 8'd0;
      end else begin
         if (inc_left && (score_l_q != 8'hFF)) begin
            score_l_d = score_l_q + 8'd1;
         end
         if (inc_right && (score_r_q != 8'hFF)) begin
            score_r_d = score_r_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_WAIT;
         idx_q        <= 2'd0;
         timer_q      <= CNT_W'(1);
         retry_q      <= 8'd0;
         torn_q       <= 1'b0;
         shadow_q     <= '{default: 8'd0};
         sel_q        <= 2'd0;
         snap_x_q     <= 8'd0;
         snap_y_q     <= 8'd0;
         snap_l_q     <= 8'd0;
         snap_r_q     <= 8'd0;
         snap_torn_q  <= 1'b0;
         snap_valid_q <= 1'b0;
         score_l_q    <= 8'd0;
         score_r_q    <= 8'd0;
         // 1 is not an edge, so a first snapshot at either edge scores.
         prev_x_q     <= 8'd1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         timer_q      <= timer_d;
         retry_q      <= retry_d;
         torn_q       <= torn_d;
         shadow_q     <= shadow_d;
         sel_q        <= sel_d;
         snap_x_q     <= snap_x_d;
         snap_y_q     <= snap_y_d;
         snap_l_q     <= snap_l_d;
         snap_r_q     <= snap_r_d;
         snap_torn_q  <= snap_torn_d;
         snap_valid_q <= snap_valid_d;
         score_l_q    <= score_l_d;
         score_r_q    <= score_r_d;
         prev_x_q     <= prev_x_d;
      end
   end

   assign sel_out     = sel_q;
   assign snap_ball_x = snap_x_q;
   assign snap_ball_y = snap_y_q;
   assign snap_lpad   = snap_l_q;
   assign snap_rpad   = snap_r_q;
   assign snap_torn   = snap_torn_q;
   assign snap_valid  = snap_valid_q;
   assign score_left  = score_l_q;
   assign score_right = score_r_q;

endmodule

// File: tb/tb_pong_state_reader.sv
// -----------------------------------------------------------------------------
// tb_pong_state_reader
//
// Bench for pong_state_reader. A small core model answers sel_out with a
// registered field value. A transaction-level model derives, from the scan
// timing rules (each field is sampled (SETTLE+1) cycles after its select,
// verify 5*(SETTLE+1) cycles after scan start) and a per-cycle history of the
// core's fields, what every output must be; a negedge process compares all
// outputs against it. Directed tests add literal expectations.
// -----------------------------------------------------------------------------
module tb_pong_state_reader;

   localparam int S    = 2;
   localparam int POLL = 8;
   localparam int MAXR = 3;
   localparam int W    = 160;
   localparam int HD   = 16384;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] sel_out;
   logic [7:0] snap_ball_x, snap_ball_y, snap_lpad, snap_rpad;
   logic       snap_torn, snap_valid;
   logic       snap_ready = 1'b1;
   logic [7:0] score_left, score_right;
   logic       score_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Core under observation: fields plus its registered multiplexed output.
   logic [7:0] f_bx = 8'd10, f_by = 8'd20, f_lp = 8'd30, f_rp = 8'd40;
   logic [7:0] core_q = 8'd0;
   always @(posedge clk) begin
      case (sel_out)
         2'd0: core_q <= f_bx;
         2'd1: core_q <= f_by;
         2'd2: core_q <= f_lp;
         default: core_q <= f_rp;
      endcase
   end

   pong_state_reader #(
      .SETTLE(S), .POLL_INTERVAL(POLL), .MAX_RETRY(MAXR), .SCREEN_WIDTH(W)
   ) dut (
      .clk(clk), .rst(rst), .sel_out(sel_out), .data_in(core_q),
      .snap_ball_x(snap_ball_x), .snap_ball_y(snap_ball_y),
      .snap_lpad(snap_lpad), .snap_rpad(snap_rpad),
      .snap_torn(snap_torn), .snap_valid(snap_valid), .snap_ready(snap_ready),
      .score_left(score_left), .score_right(score_right), .score_clr(score_clr)
   );

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   int         cyc = 0;
   logic [7:0] hist [0:3][0:HD-1];
   int         m_phase = 0;      // 0 waiting/scanning, 1 publish entry, 2 holding
   int         m_e0 = 0;         // edge at which the current scan starts
   bit         m_rst_pend = 1'b1;
   int         m_retry = 0;
   bit         m_torn = 1'b0;
   int         m_d;
   logic [7:0] m_ver;
   logic [7:0] m_cap [0:3];
   logic [7:0] e_x = 0, e_y = 0, e_l = 0, e_r = 0, e_sl = 0, e_sr = 0, e_prev = 1;
   logic       e_torn = 0, e_valid = 0;
   logic [1:0] e_sel = 0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      hist[0][cyc % HD] = f_bx;
      hist[1][cyc % HD] = f_by;
      hist[2][cyc % HD] = f_lp;
      hist[3][cyc % HD] = f_rp;
      if (rst) begin
         m_rst_pend = 1'b1; m_phase = 0; m_retry = 0; m_torn = 1'b0;
         e_x = 0; e_y = 0; e_l = 0; e_r = 0; e_sl = 0; e_sr = 0; e_prev = 1;
         e_torn = 0; e_valid = 0; e_sel = 0;
      end else begin
         if (m_rst_pend) begin
            m_rst_pend = 1'b0;
            m_e0 = cyc;
            m_phase = 0;
         end
         if (m_phase == 0) begin
            if (cyc == m_e0 + 5 * (S + 1)) begin
               // Field k sampled at edge e0+(k+1)(S+1); core output there
               // reflects the field one edge earlier.
               for (int k = 0; k < 4; k++)
                  m_cap[k] = hist[k][(m_e0 + (k + 1) * (S + 1) - 1) % HD];
               m_ver = hist[0][(cyc - 1) % HD];
               if (m_ver == m_cap[0]) begin
                  m_torn = 1'b0; m_phase = 1;
               end else if (m_retry < MAXR) begin
                  m_retry++; m_e0 = cyc;
               end else begin
                  m_torn = 1'b1; m_phase = 1;
               end
            end
         end else if (m_phase == 1) begin
            e_x = m_cap[0]; e_y = m_cap[1]; e_l = m_cap[2]; e_r = m_cap[3];
            e_torn = m_torn; e_valid = 1'b1;
            if (!m_torn) begin
               if (m_cap[0] == 8'd0 && e_prev != 8'd0 && e_sr != 8'd255) e_sr = e_sr + 8'd1;
               if (m_cap[0] == 8'(W - 1) && e_prev != 8'(W - 1) && e_sl != 8'd255) e_sl = e_sl + 8'd1;
               e_prev = m_cap[0];
            end
            m_phase = 2;
         end else begin
            if (snap_ready) begin
               e_valid = 1'b0; m_retry = 0; m_e0 = cyc + POLL; m_phase = 0;
            end
         end
         if (score_clr) begin
            e_sl = 0; e_sr = 0;
         end
         if (m_phase == 0 && cyc >= m_e0) begin
            m_d = (cyc - m_e0) / (S + 1);
            e_sel = (m_d < 4) ? 2'(m_d) : 2'd0;
         end else begin
            e_sel = 2'd0;
         end
      end
   end

   always @(negedge clk) begin
      chk("sel_out",     8'(sel_out),    8'(e_sel));
      chk("snap_valid",  8'(snap_valid), 8'(e_valid));
      chk("snap_torn",   8'(snap_torn),  8'(e_torn));
      chk("snap_ball_x", snap_ball_x,    e_x);
      chk("snap_ball_y", snap_ball_y,    e_y);
      chk("snap_lpad",   snap_lpad,      e_l);
      chk("snap_rpad",   snap_rpad,      e_r);
      chk("score_left",  score_left,     e_sl);
      chk("score_right", score_right,    e_sr);
   end

   // -------------------------------------------------------------- helpers
   task automatic wait_snap(input string nm);
      int n = 0;
      @(negedge clk);
      while (snap_valid !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (snap_valid !== 1'b1) begin
         n_tests++; n_fail++;
         $display("FAIL %s: snap_valid timeout, got %b, required 1", nm, snap_valid);
      end
   endtask

   task automatic wait_sel(input string nm, input logic [1:0] v);
      int n = 0;
      @(negedge clk);
      while (sel_out !== v && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (sel_out !== v) begin
         n_tests++; n_fail++;
         $display("FAIL %s: sel_out timeout, got %0d, required %0d", nm, sel_out, v);
      end
   endtask

   // ------------------------------------------------------------- stimulus
   initial begin
      int         lat;
      int         last_sel;
      int         sel_changes;
      logic [1:0] prev_sel;
      int         seq [$];

      // Reset state
      @(negedge clk);
      chk("reset sel_out", 8'(sel_out), 8'd0);
      chk("reset valid", 8'(snap_valid), 8'd0);
      chk("reset ball_x", snap_ball_x, 8'd0);
      chk("reset score_l", score_left, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      // T1: fixed core state, first snapshot latency and select order
      lat = 0; last_sel = -1;
      while (snap_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
         if (int'(sel_out) != last_sel) begin
            seq.push_back(int'(sel_out));
            last_sel = int'(sel_out);
         end
      end
      chk("t1 latency", 8'(lat), 8'd17);
      chk("t1 sel count", 8'(seq.size()), 8'd5);
      if (seq.size() == 5) begin
         for (int i = 0; i < 5; i++) chk("t1 sel seq", 8'(seq[i]), (i == 4) ? 8'd0 : 8'(i));
      end
      chk("t1 ball_x", snap_ball_x, 8'd10);
      chk("t1 ball_y", snap_ball_y, 8'd20);
      chk("t1 lpad", snap_lpad, 8'd30);
      chk("t1 rpad", snap_rpad, 8'd40);
      chk("t1 torn", 8'(snap_torn), 8'd0);
      $display("[TB] t1 snapshot x=%0d y=%0d l=%0d r=%0d latency=%0d", snap_ball_x, snap_ball_y, snap_lpad, snap_rpad, lat);

      // T2: ball x moves after its capture on one scan -> one retry
      wait_sel("t2", 2'd1);
      f_bx = 8'd11;
      wait_snap("t2");
      chk("t2 ball_x", snap_ball_x, 8'd11);
      chk("t2 torn", 8'(snap_torn), 8'd0);
      $display("[TB] t2 retry snapshot x=%0d torn=%0d", snap_ball_x, snap_torn);

      // T3: ball x moves during every scan -> torn after MAX_RETRY retries
      for (int i = 0; i < 4; i++) begin
         if (i > 0) wait_sel("t3", 2'd2);
         wait_sel("t3", 2'd1);
         f_bx = 8'(50 + i);
      end
      wait_snap("t3");
      chk("t3 ball_x", snap_ball_x, 8'd52);
      chk("t3 torn", 8'(snap_torn), 8'd1);
      chk("t3 score_l", score_left, 8'd0);
      chk("t3 score_r", score_right, 8'd0);
      $display("[TB] t3 torn snapshot x=%0d torn=%0d", snap_ball_x, snap_torn);

      // T4: x = 0,0,0,5,0 -> two left-edge hits
      f_bx = 8'd0;
      wait_snap("t4a");
      wait_snap("t4b");
      wait_snap("t4c");
      f_bx = 8'd5;
      wait_snap("t4d");
      f_bx = 8'd0;
      wait_snap("t4e");
      chk("t4 score_r", score_right, 8'd2);
      chk("t4 score_l", score_left, 8'd0);
      $display("[TB] t4 scores l=%0d r=%0d", score_left, score_right);

      // T5: right-edge hits saturate at 255
      for (int i = 0; i < 256; i++) begin
         f_bx = 8'd159;
         wait_snap("t5 edge");
         f_bx = 8'd1;
         wait_snap("t5 mid");
      end
      chk("t5 score_l sat", score_left, 8'd255);
      $display("[TB] t5 saturated score_l=%0d", score_left);

      // score_clr in the same cycle as an increment
      f_bx = 8'd159;
      wait_sel("t5 clr", 2'd3);
      wait_sel("t5 clr", 2'd0);
      repeat (3) @(negedge clk);
      score_clr = 1'b1;
      @(negedge clk);
      score_clr = 1'b0;
      chk("t5 clr valid", 8'(snap_valid), 8'd1);
      chk("t5 clr score_l", score_left, 8'd0);
      chk("t5 clr score_r", score_right, 8'd0);
      $display("[TB] t5 clear with increment l=%0d r=%0d", score_left, score_right);
      @(negedge clk);

      // T6: backpressure holds the snapshot and stops scanning
      snap_ready = 1'b0;
      f_bx = 8'd0; f_by = 8'd88; f_lp = 8'd99; f_rp = 8'd111;
      wait_snap("t6");
      f_bx = 8'd7; f_by = 8'd1; f_lp = 8'd2; f_rp = 8'd3;
      sel_changes = 0;
      prev_sel = sel_out;
      repeat (100) begin
         @(negedge clk);
         if (sel_out !== prev_sel) sel_changes++;
         prev_sel = sel_out;
      end
      chk("t6 valid held", 8'(snap_valid), 8'd1);
      chk("t6 ball_x", snap_ball_x, 8'd0);
      chk("t6 ball_y", snap_ball_y, 8'd88);
      chk("t6 lpad", snap_lpad, 8'd99);
      chk("t6 rpad", snap_rpad, 8'd111);
      chk("t6 sel changes", 8'(sel_changes), 8'd0);
      chk("t6 score_r", score_right, 8'd1);
      snap_ready = 1'b1;
      @(negedge clk);
      chk("t6 accept", 8'(snap_valid), 8'd0);
      $display("[TB] t6 backpressure held y=%0d sel_changes=%0d", snap_ball_y, sel_changes);

      // T7: asynchronous reset in the middle of a settle window
      f_bx = 8'd10; f_by = 8'd20; f_lp = 8'd30; f_rp = 8'd40;
      wait_sel("t7", 2'd2);
      #2 rst = 1'b1;
      #1;
      chk("t7 sel_out", 8'(sel_out), 8'd0);
      chk("t7 valid", 8'(snap_valid), 8'd0);
      chk("t7 ball_y", snap_ball_y, 8'd0);
      chk("t7 lpad", snap_lpad, 8'd0);
      chk("t7 score_r", score_right, 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_snap("t7 after reset");
      chk("t7 ball_x", snap_ball_x, 8'd10);
      chk("t7 rpad", snap_rpad, 8'd40);
      $display("[TB] t7 reset recovery x=%0d r=%0d", snap_ball_x, snap_rpad);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, time=%0t required < 2000000", $time);
      $fatal(1, "watchdog");
   end

endmodule
